// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, hold/flush and hazard flag.
// Build option: define IDEX_FORWARD_EN for forwarding/refresh/load-use; otherwise full RAW stall, no forwarding.
`timescale 1ns/1ps

`ifndef ALUop_ADD
`define ALUop_ADD 4'b0010
`endif

module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_dst,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_dst,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_dst,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] ex_busA,
    output logic [DW-1:0] ex_busB,
    output logic [3:0]    ex_aluop,
    output logic [4:0]    ex_shamt,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          load_use_stall
);

    logic          valid_q;
    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic [RW-1:0] dst_q;
    logic [4:0]    shamt_q;
    logic [3:0]    aluop_q;
    logic          alusrc_q;
    logic          regwrite_q;
    logic          memread_q;
    logic          memwrite_q;
    logic          memtoreg_q;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

`ifdef IDEX_FORWARD_EN
    // EX/MEM wins over MEM/WB; r0 is hardwired and never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_regwrite && (exmem_dst == rs_q) && (rs_q != '0))
            fwd_rs = exmem_result;
        else if (memwb_regwrite && (memwb_dst == rs_q) && (rs_q != '0))
            fwd_rs = memwb_result;
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (exmem_regwrite && (exmem_dst == rt_q) && (rt_q != '0))
            fwd_rt = exmem_result;
        else if (memwb_regwrite && (memwb_dst == rt_q) && (rt_q != '0))
            fwd_rt = memwb_result;
    end

    always_comb begin
        load_use_stall = valid_q && memread_q && (dst_q != '0) &&
                         ((dst_q == id_rs) || (dst_q == id_rt));
    end
`else
    logic unused_fwd_inputs;

    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;
    assign unused_fwd_inputs = ^{exmem_result, memwb_regwrite, memwb_dst, memwb_result};

    // Without forwarding every in-flight producer of a source register must drain first.
    always_comb begin
        load_use_stall = 1'b0;
        if (valid_q && regwrite_q && (dst_q != '0) &&
            ((dst_q == id_rs) || (dst_q == id_rt)))
            load_use_stall = 1'b1;
        if (exmem_regwrite && (exmem_dst != '0) &&
            ((exmem_dst == id_rs) || (exmem_dst == id_rt)))
            load_use_stall = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            dst_q      <= '0;
            shamt_q    <= '0;
            aluop_q    <= `ALUop_ADD;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            dst_q      <= '0;
            shamt_q    <= '0;
            aluop_q    <= `ALUop_ADD;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else if (hold) begin
`ifdef IDEX_FORWARD_EN
            // Capture forwarded operands so a retiring writeback is not lost while frozen.
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
`endif
        end else begin
            valid_q    <= id_valid;
            rs_data_q  <= id_rs_data;
            rt_data_q  <= id_rt_data;
            imm_q      <= id_imm;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            dst_q      <= id_dst;
            shamt_q    <= id_shamt;
            aluop_q    <= id_aluop;
            alusrc_q   <= id_alusrc;
            regwrite_q <= id_valid & id_regwrite;
            memread_q  <= id_valid & id_memread;
            memwrite_q <= id_valid & id_memwrite;
            memtoreg_q <= id_valid & id_memtoreg;
        end
    end

    assign ex_busA       = fwd_rs;
    assign ex_busB       = alusrc_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_aluop      = aluop_q;
    assign ex_shamt      = shamt_q;
    assign ex_dst        = dst_q;
    assign ex_valid      = valid_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;
    assign ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the IDEX_FORWARD_EN build option.
`timescale 1ns/1ps

`ifndef ALUop_ADD
`define ALUop_ADD 4'b0010
`endif

module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;
`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold, flush, id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_dst;
    logic [4:0]    id_shamt;
    logic [3:0]    id_aluop;
    logic          id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic          exmem_regwrite;
    logic [RW-1:0] exmem_dst;
    logic [DW-1:0] exmem_result;
    logic          memwb_regwrite;
    logic [RW-1:0] memwb_dst;
    logic [DW-1:0] memwb_result;
    logic [DW-1:0] ex_busA, ex_busB, ex_store_data;
    logic [3:0]    ex_aluop;
    logic [4:0]    ex_shamt;
    logic [RW-1:0] ex_dst;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic          load_use_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_shamt(id_shamt),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_aluop(ex_aluop), .ex_shamt(ex_shamt),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .load_use_stall(load_use_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hold = 0; flush = 0; id_valid = 0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_dst = '0; id_shamt = '0; id_aluop = '0;
        id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        exmem_regwrite = 0; exmem_dst = '0; exmem_result = '0;
        memwb_regwrite = 0; memwb_dst = '0; memwb_result = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_idle();
        tick();
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
        n_checks++;
        if (ex_aluop !== `ALUop_ADD) begin n_fail++; $display("FAIL reset_aluop: got %h expected %h", ex_aluop, `ALUop_ADD); end
        n_checks++;
        if ({ex_busA, ex_busB} !== '0) begin n_fail++; $display("FAIL reset_bus: got %h/%h expected 0/0", ex_busA, ex_busB); end
        n_checks++;
        if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall});
        end
        rst_n = 1;
    endtask

    task automatic test_load_fields();
        set_idle();
        id_valid = 1; id_dst = 5'd17; id_shamt = 5'd13; id_aluop = 4'h9; id_regwrite = 1;
        tick();
        n_checks++;
        if ({ex_valid, ex_regwrite, ex_dst, ex_shamt, ex_aluop} !== {1'b1, 1'b1, 5'd17, 5'd13, 4'h9}) begin
            n_fail++; $display("FAIL load_fields: got v%b rw%b dst%0d sh%0d op%h expected v1 rw1 dst17 sh13 op9",
                ex_valid, ex_regwrite, ex_dst, ex_shamt, ex_aluop);
        end
    endtask

    task automatic test_bubble_load();
        set_idle();
        id_valid = 0; id_regwrite = 1; id_memread = 1; id_memwrite = 1; id_memtoreg = 1; id_dst = 5'd7;
        tick();
        n_checks++;
        if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 5'b0) begin
            n_fail++; $display("FAIL bubble_ctrl: got %b expected 00000",
                {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg});
        end
    endtask

    task automatic test_forward_priority();
        set_idle();
        id_valid = 1; id_rs = 5'd3; id_rs_data = 32'd5; id_regwrite = 1;
        tick();
        set_idle();
        exmem_regwrite = 1; exmem_dst = 5'd3; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_dst = 5'd3; memwb_result = 32'h22;
        #1;
        n_checks++;
        if (ex_busA !== (FWD ? 32'h11 : 32'd5)) begin
            n_fail++; $display("FAIL fwd_exmem_prio: got %h expected %h", ex_busA, FWD ? 32'h11 : 32'd5);
        end
        exmem_regwrite = 0;
        #1;
        n_checks++;
        if (ex_busA !== (FWD ? 32'h22 : 32'd5)) begin
            n_fail++; $display("FAIL fwd_memwb: got %h expected %h", ex_busA, FWD ? 32'h22 : 32'd5);
        end
        id_valid = 1; id_rs = 5'd0; id_rs_data = 32'h55;
        tick();
        exmem_regwrite = 1; exmem_dst = 5'd0; memwb_regwrite = 1; memwb_dst = 5'd0;
        #1;
        n_checks++;
        if (ex_busA !== 32'h55) begin n_fail++; $display("FAIL fwd_r0: got %h expected 00000055", ex_busA); end
    endtask

    task automatic test_alusrc();
        set_idle();
        id_valid = 1; id_rt = 5'd7; id_rt_data = 32'd1; id_imm = 32'hFFFF_FFF0; id_alusrc = 1;
        tick();
        set_idle();
        exmem_regwrite = 1; exmem_dst = 5'd7; exmem_result = 32'h7;
        #1;
        n_checks++;
        if (ex_busB !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL alusrc_busB: got %h expected fffffff0", ex_busB); end
        n_checks++;
        if (ex_store_data !== (FWD ? 32'h7 : 32'h1)) begin
            n_fail++; $display("FAIL alusrc_store: got %h expected %h", ex_store_data, FWD ? 32'h7 : 32'h1);
        end
    endtask

    task automatic test_hold_refresh();
        set_idle();
        id_valid = 1; id_rt = 5'd9; id_rt_data = 32'h1; id_dst = 5'd2; id_aluop = 4'h5; id_regwrite = 1;
        tick();
        set_idle();
        hold = 1; id_valid = 1; id_dst = 5'd12; id_aluop = 4'h3; id_rt_data = 32'hDEAD;
        memwb_regwrite = 1; memwb_dst = 5'd9; memwb_result = 32'hABCD;
        #1;
        n_checks++;
        if (ex_busB !== (FWD ? 32'hABCD : 32'h1)) begin
            n_fail++; $display("FAIL hold_fwd_live: got %h expected %h", ex_busB, FWD ? 32'hABCD : 32'h1);
        end
        tick();
        memwb_regwrite = 0; memwb_dst = '0; memwb_result = 32'h1234;
        tick();
        n_checks++;
        if (ex_busB !== (FWD ? 32'hABCD : 32'h1)) begin
            n_fail++; $display("FAIL hold_refresh: got %h expected %h", ex_busB, FWD ? 32'hABCD : 32'h1);
        end
        n_checks++;
        if ({ex_valid, ex_regwrite, ex_dst, ex_aluop} !== {1'b1, 1'b1, 5'd2, 4'h5}) begin
            n_fail++; $display("FAIL hold_retain: got v%b rw%b dst%0d op%h expected v1 rw1 dst2 op5",
                ex_valid, ex_regwrite, ex_dst, ex_aluop);
        end
    endtask

    task automatic test_flush_vs_hold();
        set_idle();
        id_valid = 1; id_rs = 5'd6; id_rs_data = 32'h99; id_aluop = 4'hC;
        id_regwrite = 1; id_memread = 1; id_memwrite = 1; id_memtoreg = 1;
        tick();
        flush = 1; hold = 1;
        tick();
        n_checks++;
        if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 5'b0) begin
            n_fail++; $display("FAIL flush_ctrl: got %b expected 00000",
                {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg});
        end
        n_checks++;
        if (ex_aluop !== `ALUop_ADD || ex_busA !== '0) begin
            n_fail++; $display("FAIL flush_data: got op%h busA %h expected op%h busA 0", ex_aluop, ex_busA, `ALUop_ADD);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        id_valid = 1; id_dst = 5'd8; id_memread = 1; id_regwrite = 1; id_memtoreg = 1;
        tick();
        set_idle();
        id_rs = 5'd1; id_rt = 5'd8;
        #1;
        n_checks++;
        if (load_use_stall !== 1'b1) begin n_fail++; $display("FAIL lu_lw_rt: got %b expected 1", load_use_stall); end
        id_valid = 1; id_dst = 5'd0; id_memread = 1; id_regwrite = 1;
        tick();
        set_idle();
        #1;
        n_checks++;
        if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0: got %b expected 0", load_use_stall); end
        id_valid = 1; id_dst = 5'd4; id_regwrite = 1;
        tick();
        set_idle();
        id_rs = 5'd4;
        #1;
        n_checks++;
        if (load_use_stall !== !FWD) begin n_fail++; $display("FAIL raw_ex: got %b expected %b", load_use_stall, !FWD); end
        flush = 1;
        tick();
        set_idle();
        exmem_regwrite = 1; exmem_dst = 5'd6; id_rt = 5'd6;
        #1;
        n_checks++;
        if (load_use_stall !== !FWD) begin n_fail++; $display("FAIL raw_exmem: got %b expected %b", load_use_stall, !FWD); end
    endtask

    task automatic test_reset_mid_run();
        set_idle();
        id_valid = 1; id_rs = 5'd10; id_rs_data = 32'h77; id_rt = 5'd11; id_rt_data = 32'h66;
        id_aluop = 4'hA; id_regwrite = 1; id_memread = 1; id_dst = 5'd10;
        tick();
        id_rs = 5'd10;
        #1;
        n_checks++;
        if (ex_busA !== 32'h77 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got busA %h v%b expected 00000077 v1", ex_busA, ex_valid);
        end
        #1;
        rst_n = 0;
        #1;
        n_checks++;
        if ({ex_valid, ex_regwrite, ex_memread, load_use_stall} !== 4'b0 || ex_busA !== '0 || ex_busB !== '0) begin
            n_fail++; $display("FAIL async_reset: got v%b rw%b mr%b st%b busA %h busB %h expected all 0",
                ex_valid, ex_regwrite, ex_memread, load_use_stall, ex_busA, ex_busB);
        end
        n_checks++;
        if (ex_aluop !== `ALUop_ADD) begin n_fail++; $display("FAIL async_reset_aluop: got %h expected %h", ex_aluop, `ALUop_ADD); end
        #2;
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_load_fields();
        test_bubble_load();
        test_forward_priority();
        test_alusrc();
        test_hold_refresh();
        test_flush_vs_hold();
        test_load_use();
        test_reset_mid_run();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
